// File: rtl/button_pkg.sv
// button_pkg: shared types and helpers for the multi-channel button conditioner.
//   btn_state_t : per-channel debounce FSM state encoding (2 bits)
//   cnt_width() : width of the debounce counter (and repeat counter when built in)
// Optional feature macro: BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
package button_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    PEND_HI = 2'd1,
    HELD_HI = 2'd2,
    PEND_LO = 2'd3
  } btn_state_t;

`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
  localparam bit AUTO_REPEAT_EN = 1'b1;
`else
  localparam bit AUTO_REPEAT_EN = 1'b0;
`endif

  // One counter width serves both the debounce and the repeat counters, so
  // it must span the largest terminal count that is actually synthesised.
  function automatic int cnt_width(input int debounce, input int rdelay,
                                   input int rperiod, input bit repeat_en);
    int span;
    span = debounce;
    if (repeat_en) begin
      if (rdelay > span) span = rdelay;
      if (rperiod > span) span = rperiod;
    end
    return (span < 1) ? 1 : $clog2(span + 1);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// button_debounce_ch: one push-button channel.
//   clk            : system clock
//   reset          : asynchronous active-low reset
//   btn_raw        : raw asynchronous button input, active-high
//   btn_level      : debounced level
//   btn_press      : one-cycle pulse on accepted press (and repeat ticks)
//   btn_release    : one-cycle pulse on accepted release
//   btn_press_next : next-cycle value of btn_press, lets the parent register
//                    an OR of all channels in the same cycle as btn_press
// Optional feature macro: BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN (auto-repeat
// while held).
//
// state   | meaning
// IDLE_LO | level 0, input stable low
// PEND_HI | level 0, counting consecutive high samples
// HELD_HI | level 1, input stable high
// PEND_LO | level 1, counting consecutive low samples
module button_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 10000000,
`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
`endif
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_press_next
);
  import button_pkg::*;

  logic             sync_q1, sync_q2;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, release_d;

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_TC  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             rep_phase_q, rep_phase_d;  // 0: waiting for first repeat
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE_LO;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= btn_press_next;
      btn_release <= release_d;
    end
  end

`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q       <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    level_d        = btn_level;
    btn_press_next = 1'b0;
    release_d      = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (sync_q2) begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PEND_HI: begin
        if (!sync_q2) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d        = HELD_HI;
          cnt_d          = '0;
          level_d        = 1'b1;
          btn_press_next = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD_HI: begin
        if (!sync_q2) begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_LO: begin
        if (sync_q2) begin
          state_d = HELD_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d   = IDLE_LO;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase

`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
    // Repeat counter only advances while settled in HELD_HI; any other cycle
    // (including the entry cycle) holds it at zero so REPEAT_DELAY restarts.
    rep_d       = '0;
    rep_phase_d = 1'b0;
    if (state_q == HELD_HI && sync_q2) begin
      rep_phase_d = rep_phase_q;
      if (rep_q == (rep_phase_q ? REP_PERIOD_TC : REP_DELAY_TC)) begin
        btn_press_next = 1'b1;
        rep_d          = '0;
        rep_phase_d    = 1'b1;
      end else begin
        rep_d          = rep_q + CNT_ONE;
      end
    end
`endif
  end

endmodule

// File: rtl/button_debounce_multi.sv
// button_debounce_multi: N-channel push-button conditioner.
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   btn_in        : raw button inputs, active-high, one bit per channel
//   btn_level     : debounced level per channel
//   btn_press     : one-cycle pulse per accepted press (and repeat ticks)
//   btn_release   : one-cycle pulse per accepted release
//   btn_any_press : OR of btn_press, registered in the same cycle
// Optional feature macro: BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN (auto-repeat
// while a button is held).
module button_debounce_multi #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 10000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic            btn_any_press
);
  import button_pkg::*;

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD,
                                   AUTO_REPEAT_EN);

  logic [N_CH-1:0] press_next;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_in[g]),
      .btn_level     (btn_level[g]),
      .btn_press     (btn_press[g]),
      .btn_release   (btn_release[g]),
      .btn_press_next(press_next[g])
    );
  end

  // Built from the channels' next-press terms so it lines up with btn_press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_any_press <= 1'b0;
    else        btn_any_press <= |press_next;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
module tb_button_debounce_multi;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         btn_any_press;

  button_debounce_multi #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_any_press(btn_any_press)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run_chk = 1'b0;

  task automatic chk_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Model: a level flips once D+1 consecutive synchronised samples disagree
  // with it; synchronised sample at edge e is btn_in sampled at edge e-2.
  logic [N-1:0] h1, h2, m_lvl, e_press, e_rel;
  int           m_run  [N];
  int           m_held [N];
  logic         s;
`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
  int           prev_run;
`endif

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1 = '0; h2 = '0; m_lvl = '0; e_press = '0; e_rel = '0;
      for (int c = 0; c < N; c++) begin m_run[c] = 0; m_held[c] = 0; end
    end else begin
      for (int c = 0; c < N; c++) begin
        s = h2[c]; h2[c] = h1[c]; h1[c] = btn_in[c];
        e_press[c] = 1'b0; e_rel[c] = 1'b0;
`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
        prev_run = m_run[c];
`endif
        if (s != m_lvl[c]) begin
          m_run[c]++;
          m_held[c] = 0;
          if (m_run[c] == D + 1) begin
            m_lvl[c] = s;
            m_run[c] = 0;
            if (s) e_press[c] = 1'b1; else e_rel[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
          if (m_lvl[c]) begin
            if (prev_run == 0) begin
              m_held[c]++;
              if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RP == 0))
                e_press[c] = 1'b1;
            end else begin
              m_held[c] = 0;
            end
          end
`endif
        end
      end
    end
  end

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic         any;
  } ev_t;
  ev_t ev_q[$];

  always @(posedge clk) begin
    #2;
    if (run_chk) begin
      chk_vec("level",   btn_level,   m_lvl);
      chk_vec("press",   btn_press,   e_press);
      chk_vec("release", btn_release, e_rel);
      chk_int("any",     int'(btn_any_press), int'(|e_press));
      if ((|btn_press) || (|btn_release) || btn_any_press)
        ev_q.push_back('{cyc, btn_press, btn_release, btn_any_press});
    end
  end

  function automatic int first_press(input int ch, input int from);
    foreach (ev_q[i]) if (ev_q[i].cyc >= from && ev_q[i].press[ch]) return ev_q[i].cyc;
    return -1;
  endfunction

  function automatic int first_rel(input int ch, input int from);
    foreach (ev_q[i]) if (ev_q[i].cyc >= from && ev_q[i].rel[ch]) return ev_q[i].cyc;
    return -1;
  endfunction

  function automatic int count_press(input int ch, input int from, input int to);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i].cyc >= from && ev_q[i].cyc <= to && ev_q[i].press[ch]) n++;
    return n;
  endfunction

  function automatic logic [N-1:0] press_at(input int c);
    foreach (ev_q[i]) if (ev_q[i].cyc == c) return ev_q[i].press;
    return '0;
  endfunction

  function automatic int any_at(input int c);
    foreach (ev_q[i]) if (ev_q[i].cyc == c) return int'(ev_q[i].any);
    return 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k, k1, b0, k2, k3, g1, g2, k4, e0;

  initial begin
    reset  = 1'b0;
    btn_in = '0;
    wait_cyc(3);
    run_chk = 1'b1;
    wait_cyc(2);
    chk_vec("rst_level", btn_level, 4'b0000);
    chk_vec("rst_press", btn_press, 4'b0000);
    reset = 1'b1;
    wait_cyc(4);

    // clean press on ch0
    k = cyc + 1; btn_in[0] = 1'b1;
    wait_cyc(20);
    chk_int("press0_edge", first_press(0, k), k + 6);
    chk_int("any_press0", any_at(k + 6), 1);
`ifdef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
    chk_int("rep0_first",  first_press(0, k + 7), k + 14);
    chk_int("rep0_second", first_press(0, k + 15), k + 17);
`else
    chk_int("press0_once", count_press(0, k, cyc), 1);
`endif

    // bounce on ch1: 1,0,1,0 then steady 1
    b0 = cyc + 1;
    btn_in[1] = 1'b1; wait_cyc(1);
    btn_in[1] = 1'b0; wait_cyc(1);
    btn_in[1] = 1'b1; wait_cyc(1);
    btn_in[1] = 1'b0; wait_cyc(1);
    k1 = cyc + 1; btn_in[1] = 1'b1;
    wait_cyc(12);
    chk_int("bounce_quiet", count_press(1, b0, k1 + 5), 0);
    chk_int("bounce_press", first_press(1, b0), k1 + 6);

    // release ch0 and ch1 together
    k2 = cyc + 1; btn_in[1:0] = 2'b00;
    wait_cyc(12);
    chk_int("rel0_edge", first_rel(0, k2), k2 + 6);
    chk_int("rel1_edge", first_rel(1, k2), k2 + 6);
    chk_vec("level_after_rel", btn_level, 4'b0000);
`ifndef BUTTON_DEBOUNCE_MULTI_AUTO_REPEAT_EN
    chk_int("no_press_on_rel", count_press(0, k2, cyc), 0);
`endif

    // simultaneous press on ch2 and ch3
    k3 = cyc + 1; btn_in[3:2] = 2'b11;
    wait_cyc(12);
    chk_vec("simul_vec", press_at(k3 + 6), 4'b1100);
    chk_int("simul_any", any_at(k3 + 6), 1);
    chk_int("simul_any_before", any_at(k3 + 5), 0);
    chk_int("simul_any_after", any_at(k3 + 7), 0);
    btn_in[3:2] = 2'b00;
    wait_cyc(12);

    // boundary: exactly D high samples rejected, D+1 accepted
    g1 = cyc + 1; btn_in[2] = 1'b1;
    wait_cyc(D); btn_in[2] = 1'b0;
    wait_cyc(12);
    chk_int("glitch_D", count_press(2, g1, cyc), 0);
    g2 = cyc + 1; btn_in[2] = 1'b1;
    wait_cyc(D + 1); btn_in[2] = 1'b0;
    wait_cyc(14);
    chk_int("glitch_D1_press", first_press(2, g2), g2 + 6);
    chk_int("glitch_D1_rel",   first_rel(2, g2),   g2 + 11);

    // reset two cycles into PEND_HI with ch0 held
    k4 = cyc + 1; btn_in[0] = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(1);
    chk_vec("midrst_level", btn_level, 4'b0000);
    chk_vec("midrst_press", btn_press, 4'b0000);
    chk_int("midrst_any", int'(btn_any_press), 0);
    wait_cyc(2);
    reset = 1'b1;
    e0 = cyc + 1;
    wait_cyc(12);
    chk_int("midrst_no_pulse", count_press(0, k4, e0 + 5), 0);
    chk_int("midrst_press", first_press(0, k4), e0 + 6);
    btn_in[0] = 1'b0;
    wait_cyc(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

endmodule
